// File: rtl/ntt_coeff_stream.sv
// N x N coefficient store that streams one row or one column as N/LANES beats
// of LANES coefficients over valid/ready, while accepting single-word writes.
module ntt_coeff_stream #(
    parameter int    DATA_W    = 12,
    parameter int    N         = 128,
    parameter int    LANES     = 8,
    parameter string INIT_FILE = "",
    localparam int   IDX_W     = $clog2(N),
    localparam int   BEATS     = N / LANES,
    localparam int   BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [2*IDX_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [IDX_W-1:0]          idx_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*DATA_W-1:0]   out_data_o,
    output logic [BEAT_W-1:0]         out_beat_o,
    output logic                      out_last_o
);

    localparam int LOG_LANES = $clog2(LANES);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;
    logic [LANES*DATA_W-1:0]   data_q, data_d;

    logic [DATA_W-1:0]         mem_q [N*N];

    logic                      sel_mode;
    logic [IDX_W-1:0]          sel_idx;
    logic [BEAT_W-1:0]         beat_inc;
    logic [BEAT_W-1:0]         load_beat;
    logic [LANES*DATA_W-1:0]   rd_beat;

    // Storage is deliberately not reset; contents come from the write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // In IDLE the only possible load is a start, so steer from the live inputs.
    assign sel_mode  = (state_q == S_IDLE) ? mode_i : mode_q;
    assign sel_idx   = (state_q == S_IDLE) ? idx_i  : idx_q;
    assign beat_inc  = beat_q + BEAT_W'(1);
    assign load_beat = (state_q == S_IDLE) ? '0 : beat_inc;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IDX_W-1:0]   elem_k;
            logic [2*IDX_W-1:0] lane_addr;

            assign elem_k    = (IDX_W'(load_beat) << LOG_LANES) | IDX_W'(gi);
            assign lane_addr = sel_mode ? {elem_k, sel_idx} : {sel_idx, elem_k};
            // Read is sampled before this edge's write lands, so collisions see old data.
            assign rd_beat[gi*DATA_W +: DATA_W] = mem_q[lane_addr];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        last_d  = last_q;
        done_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    idx_d   = idx_i;
                    beat_d  = '0;
                    last_d  = (BEATS == 1);
                    data_d  = rd_beat;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready_i) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_inc;
                        last_d = (beat_inc == BEAT_W'(BEATS - 1));
                        data_d = rd_beat;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign busy_o      = (state_q == S_STREAM);
    assign out_valid_o = (state_q == S_STREAM);
    assign done_o      = done_q;
    assign out_data_o  = data_q;
    assign out_beat_o  = beat_q;
    assign out_last_o  = last_q;

endmodule

// File: tb/tb_ntt_coeff_stream.sv
// Directed bench for ntt_coeff_stream: row/column streams, backpressure,
// write collisions, mid-stream reset and start handling.
module tb_ntt_coeff_stream;

    localparam int DATA_W = 12;
    localparam int N      = 128;
    localparam int LANES  = 8;
    localparam int BEATS  = N / LANES;
    localparam int W      = LANES * DATA_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              wr_en_i;
    logic [13:0]       wr_addr_i;
    logic [11:0]       wr_data_i;
    logic              start_i;
    logic              mode_i;
    logic [6:0]        idx_i;
    logic              busy_o;
    logic              done_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [W-1:0]      out_data_o;
    logic [3:0]        out_beat_o;
    logic              out_last_o;

    logic [11:0]       model_mem [0:N*N-1];
    logic [W-1:0]      beats_seen [0:BEATS-1];
    int                checks = 0;
    int                errors = 0;

    ntt_coeff_stream #(.DATA_W(DATA_W), .N(N), .LANES(LANES), .INIT_FILE("")) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .start_i(start_i), .mode_i(mode_i), .idx_i(idx_i),
        .busy_o(busy_o), .done_o(done_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_beat_o(out_beat_o), .out_last_o(out_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_beat(input logic m, input logic [6:0] idx, input int b);
        logic [W-1:0] v;
        int k;
        v = '0;
        for (int j = 0; j < LANES; j++) begin
            k = b * LANES + j;
            v[j*DATA_W +: DATA_W] = m ? model_mem[k*N + int'(idx)] : model_mem[int'(idx)*N + k];
        end
        return v;
    endfunction

    task automatic start_stream(input logic m, input logic [6:0] idx);
        mode_i  = m;
        idx_i   = idx;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // inject: 0 plain, 1 write collisions, 2 start while busy, 3 stop at beat 7
    task automatic drain(input logic m, input logic [6:0] idx, input int inject);
        for (int b = 0; b < BEATS; b++) begin
            wr_en_i = 1'b0;
            start_i = 1'b0;
            if (inject == 3 && b == 7) return;
            chk("valid", W'(out_valid_o), W'(1));
            chk("busy", W'(busy_o), W'(1));
            chk("beat", W'(out_beat_o), W'(b));
            chk("last", W'(out_last_o), W'(b == BEATS - 1));
            chk("data", out_data_o, exp_beat(m, idx, b));
            beats_seen[b] = out_data_o;
            if (inject == 1 && b == 0) begin
                wr_en_i = 1'b1; wr_addr_i = 14'd8; wr_data_i = 12'h123;
            end
            if (inject == 1 && b == 1) model_mem[8] = 12'h123;
            if (inject == 1 && b == 5) begin
                wr_en_i = 1'b1; wr_addr_i = 14'd100; wr_data_i = 12'hABC;
                model_mem[100] = 12'hABC;
            end
            if (inject == 2 && b == 4) begin
                start_i = 1'b1; mode_i = ~m; idx_i = 7'd9;
            end
            tick();
        end
        wr_en_i = 1'b0;
        start_i = 1'b0;
        chk("done_hi", W'(done_o), W'(1));
        chk("busy_after", W'(busy_o), W'(0));
        chk("valid_after", W'(out_valid_o), W'(0));
        $display("stream mode=%0d idx=%0d beats=%0d complete", m, idx, BEATS);
    endtask

    initial begin
        int got;
        logic prev_stall;
        logic [W-1:0] prev_data;

        rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        start_i = 1'b0; mode_i = 1'b0; idx_i = '0; out_ready_i = 1'b1;
        tick(); tick();
        chk("rst_busy", W'(busy_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        chk("rst_valid", W'(out_valid_o), W'(0));
        chk("rst_data", out_data_o, W'(0));
        chk("rst_beat", W'(out_beat_o), W'(0));
        chk("rst_last", W'(out_last_o), W'(0));
        rst_i = 1'b0;

        for (int a = 0; a < N*N; a++) begin
            wr_en_i = 1'b1; wr_addr_i = 14'(a); wr_data_i = 12'(a);
            model_mem[a] = 12'(a);
            tick();
        end
        wr_en_i = 1'b0;
        $display("preload %0d words", N*N);

        // Column 5
        start_stream(1'b1, 7'd5);
        drain(1'b1, 7'd5, 0);
        chk("col5_b0", beats_seen[0], 96'h385_305_285_205_185_105_085_005);
        chk("col5_b15l7", W'(beats_seen[15][95:84]), W'(12'hF85));
        tick();
        chk("col5_done_lo", W'(done_o), W'(0));

        // Row 3
        start_stream(1'b0, 7'd3);
        drain(1'b0, 7'd3, 0);
        chk("row3_b0", beats_seen[0], 96'h187_186_185_184_183_182_181_180);
        chk("row3_b15l7", W'(beats_seen[15][95:84]), W'(12'h1FF));
        tick();

        // Backpressure on column 0
        start_stream(1'b1, 7'd0);
        got = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400 && got < BEATS; cyc++) begin
            chk("bp_valid", W'(out_valid_o), W'(1));
            chk("bp_beat", W'(out_beat_o), W'(got));
            chk("bp_data", out_data_o, exp_beat(1'b1, 7'd0, got));
            if (prev_stall) chk("bp_hold", out_data_o, prev_data);
            out_ready_i = 1'($urandom_range(0, 1));
            prev_stall = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            if (out_valid_o && out_ready_i) got++;
            tick();
        end
        chk("bp_count", W'(got), W'(BEATS));
        chk("bp_done", W'(done_o), W'(1));
        $display("backpressure stream column 0 beats=%0d", got);
        out_ready_i = 1'b1;
        tick();

        // Writes during a row 0 read
        start_stream(1'b0, 7'd0);
        drain(1'b0, 7'd0, 1);
        chk("wr_b12l4", W'(beats_seen[12][59:48]), W'(12'hABC));
        chk("wr_b1l0", W'(beats_seen[1][11:0]), W'(12'h008));
        tick();

        // Reset mid-stream at beat 7
        start_stream(1'b0, 7'd2);
        drain(1'b0, 7'd2, 3);
        chk("mid_beat7", W'(out_beat_o), W'(7));
        rst_i = 1'b1;
        #1;
        chk("mr_busy", W'(busy_o), W'(0));
        chk("mr_valid", W'(out_valid_o), W'(0));
        chk("mr_data", out_data_o, W'(0));
        chk("mr_beat", W'(out_beat_o), W'(0));
        chk("mr_last", W'(out_last_o), W'(0));
        tick();
        chk("mr_done", W'(done_o), W'(0));
        rst_i = 1'b0;
        tick();
        chk("mr_done2", W'(done_o), W'(0));
        chk("mr_valid2", W'(out_valid_o), W'(0));
        $display("reset mid-stream at beat 7");
        wr_en_i = 1'b1; wr_addr_i = 14'd0; wr_data_i = 12'h5A5;
        model_mem[0] = 12'h5A5;
        tick();
        wr_en_i = 1'b0;
        start_stream(1'b0, 7'd0);
        drain(1'b0, 7'd0, 0);
        chk("persist_a0", W'(beats_seen[0][11:0]), W'(12'h5A5));
        chk("persist_a8", W'(beats_seen[1][11:0]), W'(12'h123));
        tick();

        // Start while busy is ignored; start in the done cycle is accepted
        start_stream(1'b0, 7'd1);
        drain(1'b0, 7'd1, 2);
        mode_i = 1'b1; idx_i = 7'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        drain(1'b1, 7'd2, 0);
        chk("b2b_b0l1", W'(beats_seen[0][23:12]), W'(12'h082));
        tick();
        chk("b2b_done_lo", W'(done_o), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
